// File: rtl/sparc_ctrl_mem_unit.sv
// SPARC-subset front end: instruction memory, ID control unit, data memory.
// Optional save/restore decode is built when CU_SAVE_RESTORE_EN is defined.
module sparc_ctrl_mem_unit (
   input  logic        Clk,
   input  logic        R,
   input  logic        im_load_en,
   input  logic [8:0]  im_load_addr,
   input  logic [7:0]  im_load_data,
   input  logic [31:0] im_addr,
   output logic [31:0] im_instr,
   input  logic [31:0] cu_instr,
   output logic [15:0] cu_ctrl,
   input  logic        dm_enable,
   input  logic        dm_rw,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   input  logic [1:0]  dm_size,
   input  logic        dm_se,
   output logic [31:0] dm_rdata
);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   logic [7:0] imem [512];
   logic [7:0] dmem [512];

   // ---------------- instruction memory ----------------
   logic [8:0] ia;

   assign ia = {im_addr[8:2], 2'b00};

   always_ff @(posedge Clk) begin
      if (im_load_en)
         imem[im_load_addr] <= im_load_data;
   end

   always_comb begin
      im_instr = {imem[ia],
                  imem[ia + 9'd1],
                  imem[ia + 9'd2],
                  imem[ia + 9'd3]};
   end

   // ---------------- control unit ----------------
   logic [1:0]  op;
   logic [2:0]  op2;
   logic [5:0]  op3;
   logic [15:0] ctrl;

   assign op  = cu_instr[31:30];
   assign op2 = cu_instr[24:22];
   assign op3 = cu_instr[24:19];

   function automatic logic [1:0] ls_size(input logic [1:0] code);
      logic [1:0] s;
      case (code)
         2'b01:   s = SZ_BYTE;
         2'b10:   s = SZ_HALF;
         default: s = SZ_WORD;
      endcase
      return s;
   endfunction

   logic is_arith;
   logic is_sll;
   logic is_srl;
   logic is_sra;
   logic is_jmpl;
   logic is_savres;
   logic is_load;
   logic is_store;

   assign is_arith = (op3[5] == 1'b0);
   assign is_sll   = (op3 == 6'b100101);
   assign is_srl   = (op3 == 6'b100110);
   assign is_sra   = (op3 == 6'b100111);
   assign is_jmpl  = (op3 == 6'b111000);

`ifdef CU_SAVE_RESTORE_EN
   assign is_savres = (op3 == 6'b111100) || (op3 == 6'b111101);
`else
   assign is_savres = 1'b0;
`endif

   always_comb begin
      is_load = 1'b0;
      case (op3)
         6'b000000, 6'b000001, 6'b000010,
         6'b001001, 6'b001010: is_load = 1'b1;
         default:              is_load = 1'b0;
      endcase
   end

   always_comb begin
      is_store = 1'b0;
      case (op3)
         6'b000100, 6'b000101,
         6'b000110: is_store = 1'b1;
         default:   is_store = 1'b0;
      endcase
   end

   always_comb begin
      ctrl = 16'h0000;
      case (op)
         2'b01: begin
            ctrl[3] = 1'b1;
            ctrl[7] = 1'b1;
         end
         2'b00: begin
            case (op2)
               3'b010: begin
                  ctrl[2] = 1'b1;
                  ctrl[1] = cu_instr[29];
               end
               3'b100: begin
                  ctrl[13:10] = 4'b1011;
                  ctrl[7]     = 1'b1;
               end
               default: ctrl = 16'h0000;
            endcase
         end
         2'b10: begin
            unique case (1'b1)
               is_arith: begin
                  ctrl[13:10] = op3[3:0];
                  ctrl[7]     = 1'b1;
                  ctrl[4]     = op3[4];
               end
               is_sll: begin
                  ctrl[13:10] = 4'b1000;
                  ctrl[7]     = 1'b1;
               end
               is_srl: begin
                  ctrl[13:10] = 4'b1001;
                  ctrl[7]     = 1'b1;
               end
               is_sra: begin
                  ctrl[13:10] = 4'b1010;
                  ctrl[7]     = 1'b1;
               end
               is_jmpl: begin
                  ctrl[15] = 1'b1;
                  ctrl[7]  = 1'b1;
               end
               is_savres: begin
                  ctrl[7] = 1'b1;
               end
               default: ctrl = 16'h0000;
            endcase
         end
         default: begin
            unique case (1'b1)
               is_load: begin
                  ctrl[0]   = 1'b1;
                  ctrl[8]   = 1'b1;
                  ctrl[7]   = 1'b1;
                  ctrl[9]   = op3[3];
                  ctrl[6:5] = ls_size(op3[1:0]);
               end
               is_store: begin
                  ctrl[0]   = 1'b1;
                  ctrl[14]  = 1'b1;
                  ctrl[6:5] = ls_size(op3[1:0]);
               end
               default: ctrl = 16'h0000;
            endcase
         end
      endcase
   end

   assign cu_ctrl = R ? 16'h0000 : ctrl;

   // ---------------- data memory ----------------
   logic [8:0] wa;
   logic [8:0] ha;
   logic [8:0] ba;
   logic       dm_rd;
   logic       dm_wr;

   assign wa    = {dm_addr[8:2], 2'b00};
   assign ha    = {dm_addr[8:1], 1'b0};
   assign ba    = dm_addr[8:0];
   assign dm_rd = dm_enable && !dm_rw;
   assign dm_wr = dm_enable && dm_rw;

   always_comb begin
      dm_rdata = 32'h0;
      if (dm_rd) begin
         case (dm_size)
            SZ_BYTE: dm_rdata = {{24{dm_se & dmem[ba][7]}},
                                 dmem[ba]};
            SZ_HALF: dm_rdata = {{16{dm_se & dmem[ha][7]}},
                                 dmem[ha],
                                 dmem[ha + 9'd1]};
            default: dm_rdata = {dmem[wa],
                                 dmem[wa + 9'd1],
                                 dmem[wa + 9'd2],
                                 dmem[wa + 9'd3]};
         endcase
      end
   end

   // Reset only gates stores; the array itself is never cleared.
   always_ff @(posedge Clk) begin
      if (!R && dm_wr) begin
         case (dm_size)
            SZ_BYTE: dmem[ba] <= dm_wdata[7:0];
            SZ_HALF: begin
               dmem[ha]        <= dm_wdata[15:8];
               dmem[ha + 9'd1] <= dm_wdata[7:0];
            end
            default: begin
               dmem[wa]        <= dm_wdata[31:24];
               dmem[wa + 9'd1] <= dm_wdata[23:16];
               dmem[wa + 9'd2] <= dm_wdata[15:8];
               dmem[wa + 9'd3] <= dm_wdata[7:0];
            end
         endcase
      end
   end

   logic unused_bits;

   assign unused_bits = ^{im_addr[31:9], im_addr[1:0],
                          cu_instr[28:25], cu_instr[18:0],
                          dm_addr[31:9]};

endmodule

// File: tb/tb_sparc_ctrl_mem_unit.sv
// Directed bench for sparc_ctrl_mem_unit: fetch, decode and load/store
// vectors with hand-computed expected values.
module tb_sparc_ctrl_mem_unit;

   logic        Clk = 1'b0;
   logic        R;
   logic        im_load_en;
   logic [8:0]  im_load_addr;
   logic [7:0]  im_load_data;
   logic [31:0] im_addr;
   logic [31:0] im_instr;
   logic [31:0] cu_instr;
   logic [15:0] cu_ctrl;
   logic        dm_enable;
   logic        dm_rw;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [1:0]  dm_size;
   logic        dm_se;
   logic [31:0] dm_rdata;

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   sparc_ctrl_mem_unit dut (
      .Clk          (Clk),
      .R            (R),
      .im_load_en   (im_load_en),
      .im_load_addr (im_load_addr),
      .im_load_data (im_load_data),
      .im_addr      (im_addr),
      .im_instr     (im_instr),
      .cu_instr     (cu_instr),
      .cu_ctrl      (cu_ctrl),
      .dm_enable    (dm_enable),
      .dm_rw        (dm_rw),
      .dm_addr      (dm_addr),
      .dm_wdata     (dm_wdata),
      .dm_size      (dm_size),
      .dm_se        (dm_se),
      .dm_rdata     (dm_rdata)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic preload(input logic [8:0] a,
                          input logic [7:0] d);
      @(negedge Clk);
      im_load_en   = 1'b1;
      im_load_addr = a;
      im_load_data = d;
      @(negedge Clk);
      im_load_en   = 1'b0;
   endtask

   task automatic store(input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [1:0]  sz);
      @(negedge Clk);
      dm_enable = 1'b1;
      dm_rw     = 1'b1;
      dm_addr   = a;
      dm_wdata  = d;
      dm_size   = sz;
      @(negedge Clk);
      dm_enable = 1'b0;
      dm_rw     = 1'b0;
   endtask

   task automatic load_chk(input string tag,
                           input logic [31:0] a,
                           input logic [1:0]  sz,
                           input logic        se,
                           input logic [31:0] exp);
      @(negedge Clk);
      dm_enable = 1'b1;
      dm_rw     = 1'b0;
      dm_addr   = a;
      dm_size   = sz;
      dm_se     = se;
      #1;
      check(tag, dm_rdata, exp);
      dm_enable = 1'b0;
   endtask

   task automatic dec_chk(input string tag,
                          input logic [31:0] ins,
                          input logic [15:0] exp);
      cu_instr = ins;
      #1;
      check(tag, {16'h0, cu_ctrl}, {16'h0, exp});
   endtask

   initial begin
      R            = 1'b1;
      im_load_en   = 1'b0;
      im_load_addr = '0;
      im_load_data = '0;
      im_addr      = '0;
      cu_instr     = 32'h82004002;
      dm_enable    = 1'b0;
      dm_rw        = 1'b0;
      dm_addr      = '0;
      dm_wdata     = '0;
      dm_size      = 2'b10;
      dm_se        = 1'b0;
      #1;
      check("rst_ctrl", {16'h0, cu_ctrl}, 32'h0);
      check("rst_rdata_idle", dm_rdata, 32'h0);

      // first preload byte lands while reset is still asserted
      preload(9'd0, 8'h82);
      R = 1'b0;
      preload(9'd1, 8'h00);
      preload(9'd2, 8'h40);
      preload(9'd3, 8'h02);
      im_addr = 32'd0;
      #1;
      check("fetch0", im_instr, 32'h82004002);
      im_addr = 32'd512;
      #1;
      check("fetch512", im_instr, 32'h82004002);
      im_addr = 32'd2;
      #1;
      check("fetch_unaligned", im_instr, 32'h82004002);

      // same-cycle preload and fetch sees the old byte
      @(negedge Clk);
      im_addr      = 32'd0;
      im_load_en   = 1'b1;
      im_load_addr = 9'd0;
      im_load_data = 8'h11;
      #1;
      check("fetch_old", im_instr, 32'h82004002);
      @(negedge Clk);
      im_load_en = 1'b0;
      #1;
      check("fetch_new", im_instr, 32'h11004002);

      dec_chk("add",   32'h82004002, 16'h0080);
      dec_chk("ldub",  32'hC4082004, 16'h0181);
      dec_chk("st",    32'hC4202004, 16'h4041);
      dec_chk("ba_a",  32'h30800004, 16'h0006);
      dec_chk("sethi", 32'h03000010, 16'h2C80);
      dec_chk("call",  32'h40000010, 16'h0088);
      dec_chk("jmpl",  32'h81C3E008, 16'h8080);
      dec_chk("zero",  32'h00000000, 16'h0000);
      dec_chk("subcc", 32'h80A04002, 16'h1090);
      dec_chk("sra",   32'h81384002, 16'h2880);
      dec_chk("ldsh",  32'hC4502004, 16'h03A1);
      dec_chk("sth",   32'hC4302004, 16'h4021);
`ifdef CU_SAVE_RESTORE_EN
      dec_chk("save",  32'h9DE3BFA0, 16'h0080);
`else
      dec_chk("save",  32'h9DE3BFA0, 16'h0000);
`endif

      store(32'd8, 32'hA1B2C3D4, 2'b10);
      load_chk("ld8",   32'd8,  2'b10, 1'b0, 32'hA1B2C3D4);
      load_chk("ldsb8", 32'd8,  2'b00, 1'b1, 32'hFFFFFFA1);
      load_chk("ldub8", 32'd8,  2'b00, 1'b0, 32'h000000A1);
      load_chk("lduh10",32'd10, 2'b01, 1'b0, 32'h0000C3D4);
      load_chk("ldsh10",32'd10, 2'b01, 1'b1, 32'hFFFFC3D4);
      load_chk("ld_sz3",32'd8,  2'b11, 1'b0, 32'hA1B2C3D4);
      load_chk("ld_wrap",32'd520,2'b10,1'b0, 32'hA1B2C3D4);

      store(32'd8, 32'h0000BEEF, 2'b01);
      load_chk("ld_sth", 32'd8, 2'b10, 1'b0, 32'hBEEFC3D4);
      store(32'd11, 32'h00000055, 2'b00);
      load_chk("ld_stb", 32'd8, 2'b10, 1'b0, 32'hBEEFC355);

      @(negedge Clk);
      dm_enable = 1'b1;
      dm_rw     = 1'b1;
      dm_addr   = 32'd8;
      #1;
      check("rdata_on_write", dm_rdata, 32'h0);
      dm_enable = 1'b0;
      dm_rw     = 1'b0;

      store(32'd0, 32'hCAFEF00D, 2'b10);
      R = 1'b1;
      dec_chk("rst_add", 32'h82004002, 16'h0000);
      store(32'd0, 32'h12345678, 2'b10);
      R = 1'b0;
      load_chk("rst_nowrite", 32'd0, 2'b10, 1'b0, 32'hCAFEF00D);
      dec_chk("post_rst_add", 32'h82004002, 16'h0080);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sparc_ctrl_mem_unit.md
# sparc_ctrl_mem_unit

Front-end decode and memory block of the five-stage SPARC-subset pipeline. It combines four pieces:
- a byte-addressed instruction memory feeding IF;
- a combinational control unit producing the 16-bit ID control word;
- a byte-addressed data memory used in MEM;
- a preload port for instruction memory.

All memories are 512 bytes and big-endian. The pipeline registers and the ID hazard mux live outside this block.

## Interface
No parameters. One clock; reset `R` is synchronous and active-high.
- `Clk` in 1 — clock, rising edge.
- `R` in 1 — synchronous active-high reset.
- `im_load_en` in 1 — writes one instruction-memory byte at the clock edge.
- `im_load_addr` in 9 — byte address for the preload write.
- `im_load_data` in 8 — byte value for the preload write.
- `im_addr` in 32 — fetch address (PC).
- `im_instr` out 32 — fetched instruction word.
- `cu_instr` in 32 — instruction being decoded (IF/ID output).
- `cu_ctrl` out 16 — control word.
- `dm_enable` in 1 — data memory access enable.
- `dm_rw` in 1 — 1 = write, 0 = read.
- `dm_addr` in 32 — data byte address.
- `dm_wdata` in 32 — store data.
- `dm_size` in 2 — access size: 00 byte, 01 half, 10 word.
- `dm_se` in 1 — sign-extend loads.
- `dm_rdata` out 32 — load data.

## Operation
**Instruction memory**
- `im_instr` = {Mem[a], Mem[a+1], Mem[a+2], Mem[a+3]}, where a = {`im_addr[8:2]`, 00}.
- Address bits above bit 8 are ignored, so addresses wrap modulo 512.

**Control word fields**
- [15] jmpl
- [14] Read_Write
- [13:10] ALU_op3
- [9] SE_dm
- [8] load_instr
- [7] RF_enable
- [6:5] size_dm
- [4] modifyCC
- [3] Call_instr
- [2] B_instr
- [1] a (= instr[29] on Bicc, otherwise 0)
- [0] DataMem_enable

**Decode.** op = instr[31:30]. Every field not listed below is 0.
- op=01 (call): Call=1, RF=1, ALU=0000.
- op=00, op2=010 (Bicc): B=1, a=instr[29].
- op=00, op2=100 (sethi): RF=1, ALU=1011 (pass-immediate).
- Any other op2, including the all-zero word: control word 0x0000.
- op=10, op3[5:4]∈{00,01}: ALU=op3[3:0], RF=1, modifyCC=op3[4].
- op=10 shifts: sll 100101→1000, srl 100110→1001, sra 100111→1010; RF=1 for all three.
- op=10 jmpl (111000): jmpl=1, RF=1, ALU=0000.
- op=11 loads: ld 000000, ldub 000001, lduh 000010, ldsb 001001, ldsh 001010. Each sets DataMem_enable=1, load=1, RF=1, ALU=0000, SE_dm=op3[3], and size from op3[1:0] (00→word 10, 01→byte 00, 10→half 01).
- op=11 stores: st 000100, stb 000101, sth 000110. Each sets DataMem_enable=1, Read_Write=1, ALU=0000, size as for loads.
- Any other op3: control word 0x0000.

**Data memory**
- Word accesses are aligned to `dm_addr[8:2]`, half-word accesses to `dm_addr[8:1]`, byte accesses to `dm_addr[8:0]`.
- Reads are combinational when enable=1 and rw=0. Byte and half loads are zero- or sign-extended according to `dm_se`.
- When not reading, `dm_rdata` = 0.
- Writes occur at the rising edge when enable=1, rw=1 and R=0. Only the addressed bytes change. `dm_size`=11 is treated as word.

## Timing
- Fetch, decode and load data are purely combinational: zero latency.
- Data-memory writes and preload writes commit at the rising `Clk` edge and are visible to reads in the following cycle.
- While R=1, `cu_ctrl` is forced to 0x0000 and data writes are suppressed.
- Reset never clears either memory array. Preload writes are permitted during reset.
- `im_instr` and `dm_rdata` have no reset value; they follow array contents.
- A preload and a fetch of the same word in the same cycle: the fetch returns the old byte.

## Configuration
- `CU_SAVE_RESTORE_EN`.
  - Defined: save (111100) and restore (111101) decode as ALU=0000, RF=1, giving control word 0x0080.
  - Undefined: both decode to 0x0000.

## Test plan
- Preload bytes 82 00 40 02 at addresses 0–3, then `im_addr`=0 and `im_addr`=512 → `im_instr`=0x82004002 in both cases.
- Decode at R=0:
  - 0x82004002 (add) → 0x0080
  - 0xC4082004 (ldub) → 0x0181
  - 0xC4202004 (st) → 0x4041
  - 0x30800004 (ba,a) → 0x0006
  - sethi → 0x2C80
  - call → 0x0088
  - jmpl → 0x8080
  - 0x00000000 → 0x0000
- Store word 0xA1B2C3D4 at address 8, then:
  - ldsb @8 → 0xFFFFFFA1
  - ldub @8 → 0x000000A1
  - lduh @10 → 0x0000C3D4
  - ldsh @10 → 0xFFFFC3D4
- sth 0xBEEF @8, then ld @8 → 0xBEEFC3D4. stb 0x55 @11, then ld @8 → 0xBEEFC355.
- With R=1: `cu_instr`=0x82004002 → `cu_ctrl`=0x0000. A store of 0x12345678 @0 is not written; a read after R=0 returns the prior contents.
- save instruction → 0x0080 with `CU_SAVE_RESTORE_EN` defined, 0x0000 without.
